// File: rtl/freq_meter_pkg.sv
// Shared types and board defaults for the frequency meter.
package freq_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  // One-second gate on the 100 MHz board clock
  localparam int unsigned GATE_CYCLES_DEFAULT = 100_000_000;
  localparam int unsigned GATE_W_DEFAULT      = 27;
  localparam int unsigned CNT_W_DEFAULT       = 26;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer with a one-cycle rising-edge pulse; also used for push-buttons.
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise_c
);

  logic s1, s2, s3;

  // rst_n is active-high here, matching the rest of the board code
  always_ff @(posedge clk) begin
    if (rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise_c = s2 & ~s3;

endmodule

// File: rtl/freq_meter.sv
// Counts rising edges of sig_in over a fixed gate window of clk cycles.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = GATE_CYCLES_DEFAULT,
  parameter int unsigned GATE_W      = GATE_W_DEFAULT,
  parameter int unsigned CNT_W       = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq,
  output logic             freq_valid,
  output logic             overflow,
  output logic             busy
);

  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  state_t            state, state_nxt;
  logic [GATE_W-1:0] gate_cnt;
  logic [CNT_W-1:0]  edge_cnt;
  logic              sat;
  logic              rise_c;
  logic              edge_full_c;
  logic [CNT_W-1:0]  edge_sum_c;
  logic              sat_sum_c;

  sync_edge_det u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (sig_in),
    .rise_c   (rise_c)
  );

  // Saturating edge count including the rise seen in the current cycle
  always_comb begin
    edge_full_c = (edge_cnt == CNT_MAX);
    edge_sum_c  = edge_cnt + CNT_W'(rise_c & ~edge_full_c);
    sat_sum_c   = sat | (rise_c & edge_full_c);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (en) state_nxt = ST_MEASURE;
      ST_MEASURE: begin
        if (!en)                       state_nxt = ST_IDLE;
        else if (gate_cnt == GATE_LAST) state_nxt = ST_DONE;
      end
      ST_DONE:    state_nxt = en ? ST_MEASURE : ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Counters clear whenever a window is not in progress, so every window starts fresh
  always_ff @(posedge clk) begin
    if (rst_n) begin
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      sat        <= 1'b0;
      freq       <= '0;
      overflow   <= 1'b0;
      freq_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      freq_valid <= (state_nxt == ST_DONE);
      busy       <= (state_nxt == ST_MEASURE);
      if (state == ST_MEASURE) begin
        gate_cnt <= gate_cnt + GATE_W'(1);
        edge_cnt <= edge_sum_c;
        sat      <= sat_sum_c;
      end else begin
        gate_cnt <= '0;
        edge_cnt <= '0;
        sat      <= 1'b0;
      end
      if (state == ST_MEASURE && state_nxt == ST_DONE) begin
        freq     <= edge_sum_c;
        overflow <= sat_sum_c;
      end
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// Randomized and directed bench for freq_meter against a window-counting reference model.
module tb_freq_meter;

  localparam int unsigned G     = 1000;
  localparam longint      MAX_A = (longint'(1) << 26) - 1;
  localparam longint      MAX_B = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic        sig_man = 1'b0;
  logic        sig_gen = 1'b0;
  logic        sig_in;
  int          mode = 0;
  int          period = 10;

  logic [25:0] freq_a;
  logic        freq_valid_a, overflow_a, busy_a;
  logic [3:0]  freq_b;
  logic        freq_valid_b, overflow_b, busy_b;

  int checks = 0;
  int failures = 0;
  bit chk_on = 1'b0;

  assign sig_in = (mode == 0) ? sig_man : sig_gen;

  always #5 clk = ~clk;

  freq_meter #(.GATE_CYCLES(G), .GATE_W(10), .CNT_W(26)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .sig_in(sig_in),
    .freq(freq_a), .freq_valid(freq_valid_a), .overflow(overflow_a), .busy(busy_a)
  );

  freq_meter #(.GATE_CYCLES(G), .GATE_W(10), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .sig_in(sig_in),
    .freq(freq_b), .freq_valid(freq_valid_b), .overflow(overflow_b), .busy(busy_b)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      if (failures <= 30)
        $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Stimulus generator: periodic square wave or random runs of at least two cycles
  int ph = 0;
  int last_period = 0;
  int run = 0;
  always @(negedge clk) begin
    if (mode == 1) begin
      if (period != last_period) begin
        ph = 0;
        last_period = period;
      end
      if (ph >= period) ph = 0;
      sig_gen = (ph < period / 2);
      ph++;
    end else if (mode == 2) begin
      if (run == 0) begin
        sig_gen = ~sig_gen;
        run = $urandom_range(2, 9);
      end
      run--;
    end
  end

  // Reference model: windows are spans of G posedges; the count is the number of
  // 0->1 transitions in the sampled input, shifted by the synchronizer delay.
  bit     hist [0:65535];
  int     cyc = 3;
  int     start = 0;
  bit     active = 1'b0;
  bit     m_valid = 1'b0;
  longint m_fa = 0, m_fb = 0;
  bit     m_oa = 1'b0, m_ob = 1'b0;

  always @(posedge clk) begin
    longint n;
    cyc++;
    if (cyc > 65000) begin
      $display("FAIL cycle_budget: got %0d expected below 65000", cyc);
      $fatal(1);
    end
    m_valid = 1'b0;
    if (rst_n) begin
      hist[cyc] = 1'b0;
      hist[cyc-1] = 1'b0;
      hist[cyc-2] = 1'b0;
      active = 1'b0;
      m_fa = 0; m_fb = 0; m_oa = 1'b0; m_ob = 1'b0;
    end else begin
      hist[cyc] = sig_in;
      if (active) begin
        if (!en) active = 1'b0;
        else if (cyc == start + int'(G)) begin
          n = 0;
          for (int p = start + 1; p <= start + int'(G); p++)
            if (hist[p-2] && !hist[p-3]) n++;
          m_fa = (n > MAX_A) ? MAX_A : n;
          m_oa = (n > MAX_A);
          m_fb = (n > MAX_B) ? MAX_B : n;
          m_ob = (n > MAX_B);
          m_valid = 1'b1;
          active = 1'b0;
        end
      end else if (en) begin
        start = cyc;
        active = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check_eq("valid_a", 64'(freq_valid_a), 64'(m_valid));
      check_eq("freq_a",  64'(freq_a),       64'(m_fa));
      check_eq("ovf_a",   64'(overflow_a),   64'(m_oa));
      check_eq("busy_a",  64'(busy_a),       64'(active));
      check_eq("valid_b", 64'(freq_valid_b), 64'(m_valid));
      check_eq("freq_b",  64'(freq_b),       64'(m_fb));
      check_eq("ovf_b",   64'(overflow_b),   64'(m_ob));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input int budget, output int k, output bit got);
    k = 0;
    got = 1'b0;
    while (!got && k < budget) begin
      @(negedge clk);
      k++;
      got = freq_valid_a;
    end
  endtask

  initial begin
    int  k;
    bit  got;

    // Reset state
    rst_n = 1'b1;
    step(3);
    check_eq("rst_freq",  64'(freq_a), 64'd0);
    check_eq("rst_valid", 64'(freq_valid_a), 64'd0);
    check_eq("rst_busy",  64'(busy_a), 64'd0);
    check_eq("rst_ovf",   64'(overflow_a), 64'd0);
    rst_n = 1'b0;
    chk_on = 1'b1;
    step(2);

    // Period 10: 100 edges, back-to-back spacing of G+1
    mode = 1; period = 10;
    step(20);
    en = 1'b1;
    wait_valid(1100, k, got);
    check_eq("t1_got", 64'(got), 64'd1);
    check_eq("t1_lat", 64'(k), 64'(G + 1));
    check_eq("t1_freq", 64'(freq_a), 64'd100);
    check_eq("t1_ovf", 64'(overflow_a), 64'd0);
    wait_valid(1100, k, got);
    check_eq("t1_spacing", 64'(k), 64'(G + 1));
    check_eq("t1_freq2", 64'(freq_a), 64'd100);
    check_eq("t1_sat_b", 64'(freq_b), 64'd15);
    en = 1'b0;

    // Input held low
    mode = 0; sig_man = 1'b0;
    step(10);
    en = 1'b1;
    wait_valid(1100, k, got);
    check_eq("t2_lat", 64'(k), 64'(G + 1));
    check_eq("t2_freq", 64'(freq_a), 64'd0);
    check_eq("t2_ovf", 64'(overflow_a), 64'd0);
    en = 1'b0;

    // Saturation on the narrow counter, then cleared on the next window
    mode = 1; period = 4;
    step(20);
    en = 1'b1;
    wait_valid(1100, k, got);
    check_eq("t3_freq_a", 64'(freq_a), 64'd250);
    check_eq("t3_freq_b", 64'(freq_b), 64'd15);
    check_eq("t3_ovf_b", 64'(overflow_b), 64'd1);
    en = 1'b0;
    period = 100;
    step(200);
    en = 1'b1;
    wait_valid(1100, k, got);
    check_eq("t3_freq_b2", 64'(freq_b), 64'd10);
    check_eq("t3_ovf_b2", 64'(overflow_b), 64'd0);
    en = 1'b0;

    // Abort mid-window keeps the previous result
    period = 10;
    step(20);
    en = 1'b1;
    wait_valid(1100, k, got);
    check_eq("t4_freq", 64'(freq_a), 64'd100);
    step(500);
    en = 1'b0;
    step(1);
    check_eq("t4_busy", 64'(busy_a), 64'd0);
    wait_valid(1200, k, got);
    check_eq("t4_novalid", 64'(got), 64'd0);
    check_eq("t4_hold", 64'(freq_a), 64'd100);

    // Reset on the cycle that would enter DONE
    en = 1'b1;
    step(int'(G));
    rst_n = 1'b1;
    en = 1'b0;
    step(1);
    check_eq("t5_valid", 64'(freq_valid_a), 64'd0);
    check_eq("t5_freq", 64'(freq_a), 64'd0);
    check_eq("t5_busy", 64'(busy_a), 64'd0);
    rst_n = 1'b0;
    step(5);
    en = 1'b1;
    wait_valid(1100, k, got);
    check_eq("t5_lat", 64'(k), 64'(G + 1));
    check_eq("t5_freq2", 64'(freq_a), 64'd100);
    en = 1'b0;

    // Single rise landing in the last MEASURE cycle, then one cycle later in DONE
    mode = 0; sig_man = 1'b0;
    step(10);
    en = 1'b1;
    step(int'(G) - 2);
    sig_man = 1'b1;
    wait_valid(20, k, got);
    check_eq("t6_got", 64'(got), 64'd1);
    check_eq("t6_last", 64'(freq_a), 64'd1);
    en = 1'b0;
    sig_man = 1'b0;
    step(10);
    en = 1'b1;
    step(int'(G) - 1);
    sig_man = 1'b1;
    wait_valid(20, k, got);
    check_eq("t6_done", 64'(freq_a), 64'd0);
    en = 1'b0;
    sig_man = 1'b0;
    step(10);

    // Random input, continuous windows, random aborts and a random reset
    mode = 2;
    en = 1'b1;
    repeat (4) begin
      wait_valid(1100, k, got);
      check_eq("rnd_got", 64'(got), 64'd1);
    end
    repeat (3) begin
      step($urandom_range(50, 900));
      en = 1'b0;
      step($urandom_range(1, 20));
      en = 1'b1;
    end
    step($urandom_range(100, 900));
    rst_n = 1'b1;
    step(2);
    rst_n = 1'b0;
    wait_valid(1100, k, got);
    check_eq("rnd_post_rst", 64'(got), 64'd1);
    en = 1'b0;
    step(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
